// File: rtl/ibram_multibuf_bank_if.sv
// Bus bundle for ibram_multibuf_bank: broadcast and per-bank write streams,
// plus the per-bank descriptor / narrow read / release port.
interface ibram_multibuf_bank_if #(
  parameter int NUM_BANKS   = 16,
  parameter int NUM_BUFS    = 2,
  parameter int WRITE_WIDTH = 128,
  parameter int WRITE_DEPTH = 128,
  parameter int READ_WIDTH  = 8
);
  localparam int READ_DEPTH = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH;
  localparam int LEN_W      = $clog2(WRITE_DEPTH) + 1;
  localparam int RA_W       = $clog2(READ_DEPTH);
  localparam int FC_W       = $clog2(NUM_BUFS) + 1;

  logic                                   mode;
  logic [WRITE_WIDTH-1:0]                 s_data;
  logic                                   s_valid;
  logic                                   s_last;
  logic [NUM_BANKS-1:0]                   s_bank_sel;
  logic                                   s_ready;
  logic [NUM_BANKS-1:0][WRITE_WIDTH-1:0]  p_data;
  logic [NUM_BANKS-1:0]                   p_valid;
  logic [NUM_BANKS-1:0]                   p_last;
  logic [NUM_BANKS-1:0]                   p_ready;
  logic [NUM_BANKS-1:0]                   rd_valid;
  logic [NUM_BANKS-1:0][LEN_W-1:0]        rd_len;
  logic [NUM_BANKS-1:0]                   rd_en;
  logic [NUM_BANKS-1:0][RA_W-1:0]         rd_addr;
  logic [NUM_BANKS-1:0][READ_WIDTH-1:0]   rd_data;
  logic [NUM_BANKS-1:0]                   rd_release;
  logic [NUM_BANKS-1:0][FC_W-1:0]         fill_count;

  modport master (
    output mode, s_data, s_valid, s_last, s_bank_sel,
    output p_data, p_valid, p_last, rd_en, rd_addr, rd_release,
    input  s_ready, p_ready, rd_valid, rd_len, rd_data, fill_count
  );

  modport slave (
    input  mode, s_data, s_valid, s_last, s_bank_sel,
    input  p_data, p_valid, p_last, rd_en, rd_addr, rd_release,
    output s_ready, p_ready, rd_valid, rd_len, rd_data, fill_count
  );
endinterface

// File: rtl/ibram_multibuf_bank.sv
// Input-activation buffer bank: each bank owns NUM_BUFS rotating buffers.
// Writers fill the buffer at wr_ptr (broadcast or per-bank stream); closed
// buffers are exposed to the reader as {valid, length} and freed by release.
// WRITE_DEPTH, NUM_BUFS and WRITE_WIDTH/READ_WIDTH are assumed powers of two
// with READ_WIDTH < WRITE_WIDTH, so addresses split into plain bit fields.
module ibram_multibuf_bank #(
  parameter int NUM_BANKS   = 16,
  parameter int NUM_BUFS    = 2,
  parameter int WRITE_WIDTH = 128,
  parameter int WRITE_DEPTH = 128,
  parameter int READ_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  ibram_multibuf_bank_if.slave bus
);
  localparam int READ_DEPTH = WRITE_WIDTH * WRITE_DEPTH / READ_WIDTH;
  localparam int R          = WRITE_WIDTH / READ_WIDTH;
  localparam int PW         = $clog2(NUM_BUFS);
  localparam int WA         = $clog2(WRITE_DEPTH);
  localparam int RA         = $clog2(READ_DEPTH);
  localparam int LW         = $clog2(R);
  localparam int CW         = PW + 1;
  localparam int LEN_W      = WA + 1;

  localparam logic [CW-1:0] FULL_C      = CW'(NUM_BUFS);
  localparam logic [WA-1:0] LAST_ADDR_C = WA'(WRITE_DEPTH - 1);

  // Per-bank state
  logic [NUM_BANKS-1:0][PW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [NUM_BANKS-1:0][PW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [NUM_BANKS-1:0][CW-1:0]                  cnt_q, cnt_d;
  logic [NUM_BANKS-1:0][WA-1:0]                  wr_addr_q, wr_addr_d;
  logic [NUM_BANKS-1:0][NUM_BUFS-1:0][LEN_W-1:0] len_q, len_d;
  logic [NUM_BANKS-1:0][READ_WIDTH-1:0]          rd_data_q, rd_data_d;
  logic [NUM_BANKS-1:0]                          p_ready_q, p_ready_d;
  logic                                          active_mode_q, active_mode_d;

  // Buffer storage: one simple dual-port array per bank, indexed {buffer, word}
  logic [WRITE_WIDTH-1:0] mem [NUM_BANKS][NUM_BUFS*WRITE_DEPTH];

  logic [NUM_BANKS-1:0]                  bank_ready_s;
  logic [NUM_BANKS-1:0]                  wr_en_s;
  logic [NUM_BANKS-1:0][WRITE_WIDTH-1:0] wr_data_s;
  logic [NUM_BANKS-1:0]                  close_s;
  logic [NUM_BANKS-1:0]                  release_s;
  logic [NUM_BANKS-1:0]                  rd_valid_s;
  logic [NUM_BANKS-1:0][LEN_W-1:0]       rd_len_s;
  logic                                  s_ready_s;
  logic                                  all_idle_s;

  // Write-side steering: pick the stream for the latched mode and form transfers
  always_comb begin
    bank_ready_s = '0;
    wr_en_s      = '0;
    wr_data_s    = '0;
    close_s      = '0;
    s_ready_s    = ~active_mode_q;
    all_idle_s   = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_ready_s[b] = (cnt_q[b] < FULL_C);
      s_ready_s       = s_ready_s & (bank_ready_s[b] | ~bus.s_bank_sel[b]);
      all_idle_s      = all_idle_s & (wr_addr_q[b] == '0);
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (active_mode_q) begin
        wr_en_s[b]   = bus.p_valid[b] & p_ready_q[b] & bank_ready_s[b];
        wr_data_s[b] = bus.p_data[b];
        close_s[b]   = wr_en_s[b] & (bus.p_last[b] | (wr_addr_q[b] == LAST_ADDR_C));
      end else begin
        wr_en_s[b]   = bus.s_valid & s_ready_s & bus.s_bank_sel[b];
        wr_data_s[b] = bus.s_data;
        close_s[b]   = wr_en_s[b] & (bus.s_last | (wr_addr_q[b] == LAST_ADDR_C));
      end
    end
  end

  // Next-state for pointers, counts, descriptors, read data and mode
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    len_d      = len_q;
    rd_data_d  = rd_data_q;
    release_s  = '0;
    rd_valid_s = '0;
    rd_len_s   = '0;
    p_ready_d  = '0;
    // A mode switch only takes effect between buffers so no buffer mixes streams
    if (all_idle_s) begin
      active_mode_d = bus.mode;
    end else begin
      active_mode_d = active_mode_q;
    end
    for (int b = 0; b < NUM_BANKS; b++) begin
      rd_valid_s[b] = (cnt_q[b] != '0);
      rd_len_s[b]   = len_q[b][rd_ptr_q[b]];
      release_s[b]  = bus.rd_release[b] & rd_valid_s[b];
      if (wr_en_s[b]) begin
        if (close_s[b]) begin
          len_d[b][wr_ptr_q[b]] = {1'b0, wr_addr_q[b]} + LEN_W'(1);
          wr_ptr_d[b]           = wr_ptr_q[b] + PW'(1);
          wr_addr_d[b]          = '0;
        end else begin
          wr_addr_d[b] = wr_addr_q[b] + WA'(1);
        end
      end else begin
        wr_addr_d[b] = wr_addr_q[b];
      end
      if (release_s[b]) begin
        rd_ptr_d[b] = rd_ptr_q[b] + PW'(1);
      end else begin
        rd_ptr_d[b] = rd_ptr_q[b];
      end
      case ({close_s[b], release_s[b]})
        2'b10:   cnt_d[b] = cnt_q[b] + CW'(1);
        2'b01:   cnt_d[b] = cnt_q[b] - CW'(1);
        default: cnt_d[b] = cnt_q[b];
      endcase
      // Read uses the pre-release head, so a same-cycle release still reads it
      if (bus.rd_en[b] & rd_valid_s[b]) begin
        rd_data_d[b] = mem[b][{rd_ptr_q[b], bus.rd_addr[b][RA-1:LW]}]
                         [bus.rd_addr[b][LW-1:0]*READ_WIDTH +: READ_WIDTH];
      end else begin
        rd_data_d[b] = rd_data_q[b];
      end
      p_ready_d[b] = active_mode_d & (cnt_d[b] < FULL_C);
    end
  end

  // State registers; reset discards every buffer and reopens all write ports
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      wr_addr_q     <= '0;
      len_q         <= '0;
      rd_data_q     <= '0;
      p_ready_q     <= '1;
      active_mode_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      wr_addr_q     <= wr_addr_d;
      len_q         <= len_d;
      rd_data_q     <= rd_data_d;
      p_ready_q     <= p_ready_d;
      active_mode_q <= active_mode_d;
    end
  end

  // Buffer memory write port (contents are not reset)
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (wr_en_s[b]) begin
        mem[b][{wr_ptr_q[b], wr_addr_q[b]}] <= wr_data_s[b];
      end
    end
  end

  assign bus.s_ready    = s_ready_s;
  assign bus.p_ready    = p_ready_q;
  assign bus.rd_valid   = rd_valid_s;
  assign bus.rd_len     = rd_len_s;
  assign bus.rd_data    = rd_data_q;
  assign bus.fill_count = cnt_q;
endmodule

// File: tb/tb_ibram_multibuf_bank.sv
// Scoreboard bench for ibram_multibuf_bank: stimulus pushes expectations with
// the cycle they are due, a monitor pops and compares them on falling edges.
module tb_ibram_multibuf_bank;
  localparam int K_VALID = 0, K_LEN = 1, K_FILL = 2, K_PRDY = 3, K_SRDY = 4, K_RDATA = 5;

  typedef struct {
    int          due;
    int          kind;
    int          bank;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibram_multibuf_bank_if bif ();
  ibram_multibuf_bank dut (.clk(clk), .rst(rst), .bus(bif));

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dut_val(input int kind, input int bank);
    case (kind)
      K_VALID: return 32'(bif.rd_valid[bank]);
      K_LEN:   return 32'(bif.rd_len[bank]);
      K_FILL:  return 32'(bif.fill_count[bank]);
      K_PRDY:  return 32'(bif.p_ready[bank]);
      K_SRDY:  return 32'(bif.s_ready);
      K_RDATA: return 32'(bif.rd_data[bank]);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation that has come due
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e   = q.pop_front();
        act = dut_val(e.kind, e.bank);
        vectors++;
        if (act !== e.val) begin
          miscompares++;
          $display("FAIL %s bank %0d: got 0x%0h, expected 0x%0h", e.name, e.bank, act, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input int bank, input logic [31:0] val, input string name);
    exp_t e;
    e.due = cyc; e.kind = kind; e.bank = bank; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic expect_rd(input int bank, input logic [31:0] val);
    exp_t e;
    e.due = cyc + 1; e.kind = K_RDATA; e.bank = bank; e.val = val; e.name = "rd_data";
    q.push_back(e);
  endtask

  task automatic pwr(input int b, input logic [127:0] data, input logic last);
    bif.p_valid[b] = 1'b1;
    bif.p_data[b]  = data;
    bif.p_last[b]  = last;
    tick();
    bif.p_valid[b] = 1'b0;
    bif.p_last[b]  = 1'b0;
  endtask

  task automatic swr(input logic [127:0] data, input logic last);
    bif.s_valid = 1'b1;
    bif.s_data  = data;
    bif.s_last  = last;
    tick();
    bif.s_valid = 1'b0;
    bif.s_last  = 1'b0;
  endtask

  task automatic rd(input int b, input int addr, input logic [31:0] val);
    bif.rd_en[b]   = 1'b1;
    bif.rd_addr[b] = 11'(addr);
    expect_rd(b, val);
    tick();
    bif.rd_en[b] = 1'b0;
  endtask

  task automatic rel(input int b);
    bif.rd_release[b] = 1'b1;
    tick();
    bif.rd_release[b] = 1'b0;
  endtask

  initial begin
    bif.mode = 1'b0;      bif.s_data = '0;  bif.s_valid = 1'b0; bif.s_last = 1'b0;
    bif.s_bank_sel = '0;  bif.p_data = '0;  bif.p_valid = '0;   bif.p_last = '0;
    bif.rd_en = '0;       bif.rd_addr = '0; bif.rd_release = '0;

    // Reset state
    tick(); tick();
    expect_now(K_VALID, 0, 32'd0, "reset rd_valid");
    expect_now(K_FILL,  0, 32'd0, "reset fill_count");
    expect_now(K_PRDY,  0, 32'd1, "reset p_ready");
    expect_now(K_SRDY,  0, 32'd1, "reset s_ready");
    tick();
    rst = 1'b0;
    tick();

    // Mode 1, bank 3: five words, last on the fifth
    bif.mode = 1'b1;
    tick(); tick();
    expect_now(K_PRDY, 3, 32'd1, "mode1 p_ready");
    expect_now(K_SRDY, 0, 32'd0, "mode1 s_ready");
    for (int i = 1; i <= 5; i++) pwr(3, 128'(i), (i == 5));
    expect_now(K_VALID, 3, 32'd1, "b3 rd_valid");
    expect_now(K_LEN,   3, 32'd5, "b3 rd_len");
    expect_now(K_FILL,  3, 32'd1, "b3 fill_count");
    rd(3, 16, 32'h02);
    rd(3, 64, 32'h05);
    rd(3, 17, 32'h00);
    rel(3);
    expect_now(K_VALID, 3, 32'd0, "b3 released");

    // Mode 0 broadcast to banks 0 and 2, 128 words, auto-close
    bif.mode = 1'b0;
    tick();
    expect_now(K_SRDY, 0, 32'd1, "mode0 s_ready");
    expect_now(K_PRDY, 3, 32'd0, "mode0 p_ready");
    bif.s_bank_sel = 16'h0005;
    for (int i = 0; i < 128; i++) swr(128'(i), 1'b0);
    expect_now(K_LEN,   0, 32'd128, "b0 auto len");
    expect_now(K_LEN,   2, 32'd128, "b2 auto len");
    expect_now(K_FILL,  0, 32'd1,   "b0 auto fill");
    expect_now(K_FILL,  2, 32'd1,   "b2 auto fill");
    expect_now(K_FILL,  1, 32'd0,   "b1 untouched fill");
    expect_now(K_VALID, 1, 32'd0,   "b1 untouched valid");
    rd(2, 2032, 32'h7F);
    rd(0, 80, 32'h05);
    rel(0);
    rel(2);
    bif.s_bank_sel = '0;

    // Full bank stalls, release reopens, same-cycle read returns old head
    bif.mode = 1'b1;
    tick();
    pwr(4, 128'hA1, 1'b0);
    pwr(4, 128'hA2, 1'b1);
    pwr(4, 128'hB1, 1'b1);
    expect_now(K_FILL, 4, 32'd2, "b4 full fill");
    expect_now(K_PRDY, 4, 32'd0, "b4 full p_ready");
    bif.p_valid[4] = 1'b1; bif.p_data[4] = 128'hC1; bif.p_last[4] = 1'b0;
    tick();
    expect_now(K_FILL, 4, 32'd2, "b4 stalled fill");
    expect_now(K_PRDY, 4, 32'd0, "b4 stalled p_ready");
    bif.rd_release[4] = 1'b1; bif.rd_en[4] = 1'b1; bif.rd_addr[4] = 11'd16;
    expect_rd(4, 32'hA2);
    tick();
    bif.rd_release[4] = 1'b0; bif.rd_en[4] = 1'b0;
    expect_now(K_PRDY, 4, 32'd1, "b4 reopened p_ready");
    expect_now(K_FILL, 4, 32'd1, "b4 after release fill");
    expect_now(K_LEN,  4, 32'd1, "b4 new head len");
    tick();
    bif.p_valid[4] = 1'b0;
    // Close and release together with one buffer held
    bif.p_valid[4] = 1'b1; bif.p_data[4] = 128'hC2; bif.p_last[4] = 1'b1;
    bif.rd_release[4] = 1'b1;
    tick();
    bif.p_valid[4] = 1'b0; bif.p_last[4] = 1'b0; bif.rd_release[4] = 1'b0;
    expect_now(K_FILL,  4, 32'd1, "b4 close+release fill");
    expect_now(K_LEN,   4, 32'd2, "b4 close+release len");
    expect_now(K_VALID, 4, 32'd1, "b4 close+release valid");
    rd(4, 0, 32'hC1);
    rd(4, 16, 32'hC2);
    rel(4);
    expect_now(K_VALID, 4, 32'd0, "b4 drained");

    // Mode change deferred while bank 1 is mid-buffer
    bif.mode = 1'b0;
    tick();
    bif.s_bank_sel = 16'h0002;
    for (int i = 1; i <= 3; i++) swr(128'(8'hD0 + i), 1'b0);
    bif.mode = 1'b1;
    tick(); tick();
    expect_now(K_PRDY, 1, 32'd0, "deferred p_ready");
    expect_now(K_SRDY, 0, 32'd1, "deferred s_ready");
    expect_now(K_FILL, 1, 32'd0, "deferred fill");
    swr(128'hD4, 1'b1);
    expect_now(K_PRDY, 1, 32'd0, "close edge p_ready");
    expect_now(K_LEN,  1, 32'd4, "b1 len");
    expect_now(K_FILL, 1, 32'd1, "b1 fill");
    tick();
    expect_now(K_PRDY, 1, 32'd1, "mode1 applied p_ready");
    expect_now(K_SRDY, 0, 32'd0, "mode1 applied s_ready");
    bif.s_bank_sel = '0;

    // Reset mid-fill with a full bank
    pwr(5, 128'hE1, 1'b1);
    pwr(5, 128'hE2, 1'b1);
    pwr(6, 128'hF1, 1'b0);
    expect_now(K_FILL, 5, 32'd2, "b5 full fill");
    expect_now(K_PRDY, 5, 32'd0, "b5 full p_ready");
    tick();
    rst = 1'b1;
    #1;
    expect_now(K_VALID, 5, 32'd0, "rst rd_valid b5");
    expect_now(K_FILL,  5, 32'd0, "rst fill b5");
    expect_now(K_VALID, 1, 32'd0, "rst rd_valid b1");
    expect_now(K_PRDY,  5, 32'd1, "rst p_ready b5");
    expect_now(K_SRDY,  0, 32'd1, "rst s_ready");
    tick();
    rst = 1'b0;
    tick();
    rel(5);
    expect_now(K_FILL,  5, 32'd0, "empty release fill");
    expect_now(K_VALID, 5, 32'd0, "empty release valid");
    expect_now(K_PRDY,  5, 32'd1, "empty release p_ready");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    tick();
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: got %0d pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
